// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode and time-base controller for the digital clock.
// Derives the 1 Hz seconds tick, runs the RUN / SET_HR / SET_MIN mode
// machine, turns debounced button levels into one-cycle strobes for the
// hh:mm:ss counters and drives the blink enable of the field being set.
// Optional build macro CLOCK_AUTOREPEAT_EN adds auto-repeat on a held
// btn_inc; without it exactly one strobe is issued per btn_inc rise.
module clock_set_ctrl #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink
);
    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = $clog2(CLK_HZ / 4);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(CLK_HZ / 4 - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          sec_tick_q, sec_tick_d;
    logic          inc_hr_q, inc_hr_d;
    logic          inc_min_q, inc_min_d;
    logic          clr_sec_q, clr_sec_d;
    // Button sample (_s) and previous sample (_p) used for rise detection
    logic          mode_s_q, mode_p_q;
    logic          inc_s_q, inc_p_q;
    logic          mode_rise, inc_rise, inc_fire, presc_wrap;

`ifdef CLOCK_AUTOREPEAT_EN
    // Hold counter: 1 on the rise, first repeat when it reaches CLK_HZ,
    // then reloaded so the next repeat lands CLK_HZ/4 cycles later.
    localparam int HW = $clog2(CLK_HZ) + 1;
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(CLK_HZ);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(CLK_HZ - CLK_HZ / 4 + 1);
    logic [HW-1:0] hold_q, hold_d;
`endif

    // Next-state logic for the mode machine, time base, strobes and blink
    always_comb begin
        mode_rise = mode_s_q & ~mode_p_q;
        inc_rise  = inc_s_q & ~inc_p_q;

        mode_d = mode_q;
        if (mode_rise) begin
            case (mode_q)
                RUN:     mode_d = SET_HR;
                SET_HR:  mode_d = SET_MIN;
                default: mode_d = RUN;
            endcase
        end

        // Prescaler only runs while staying in RUN; leaving a set mode
        // restarts it from 0 so the next tick is a full second away.
        presc_wrap = (presc_q == PRESC_MAX);
        if (mode_q != RUN || mode_d != RUN) begin
            presc_d = '0;
        end else if (presc_wrap) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        sec_tick_d = presc_wrap && mode_q == RUN && mode_d == RUN;

        clr_sec_d = mode_rise && mode_q == SET_MIN;

        // A simultaneous mode rise discards the increment
        inc_fire = inc_rise && !mode_rise && mode_q != RUN;
`ifdef CLOCK_AUTOREPEAT_EN
        hold_d = '0;
        if (inc_s_q && !mode_rise && mode_q != RUN) begin
            if (inc_rise) begin
                hold_d = HOLD_ONE;
            end else if (hold_q == HOLD_MAX) begin
                hold_d   = HOLD_RELOAD;
                inc_fire = 1'b1;
            end else if (hold_q != '0) begin
                hold_d = hold_q + 1'b1;
            end
        end
`endif
        inc_hr_d  = inc_fire && mode_q == SET_HR;
        inc_min_d = inc_fire && mode_q == SET_MIN;

        if (mode_d == RUN) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (mode_q == RUN) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // State and registered outputs; reset loads the button history with the
    // live level so a button held through reset cannot produce a rise
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            sec_tick_q  <= 1'b0;
            inc_hr_q    <= 1'b0;
            inc_min_q   <= 1'b0;
            clr_sec_q   <= 1'b0;
            mode_s_q    <= btn_mode;
            mode_p_q    <= btn_mode;
            inc_s_q     <= btn_inc;
            inc_p_q     <= btn_inc;
`ifdef CLOCK_AUTOREPEAT_EN
            hold_q      <= '0;
`endif
        end else begin
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            sec_tick_q  <= sec_tick_d;
            inc_hr_q    <= inc_hr_d;
            inc_min_q   <= inc_min_d;
            clr_sec_q   <= clr_sec_d;
            mode_s_q    <= btn_mode;
            mode_p_q    <= mode_s_q;
            inc_s_q     <= btn_inc;
            inc_p_q     <= inc_s_q;
`ifdef CLOCK_AUTOREPEAT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign mode     = mode_q;
    assign sec_tick = sec_tick_q;
    assign inc_hr   = inc_hr_q;
    assign inc_min  = inc_min_q;
    assign clr_sec  = clr_sec_q;
    assign blink    = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with CLK_HZ=8: directed scenarios with literal
// expectations plus randomized button/reset activity, all checked every
// cycle against an event-level model built from cycle indices.
module tb_clock_set_ctrl;
    localparam int HZ = 8;
    localparam int Q  = HZ / 4;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] mode;
    logic       sec_tick, inc_hr, inc_min, clr_sec, blink;

    int n_vec = 0;
    int n_err = 0;

    clock_set_ctrl #(.CLK_HZ(HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .mode     (mode),
        .sec_tick (sec_tick),
        .inc_hr   (inc_hr),
        .inc_min  (inc_min),
        .clr_sec  (clr_sec),
        .blink    (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is an edge index e. Seconds ticks fall on multiples of HZ after
    // the edge that (re)started RUN; blink phase is (e - set entry)/Q;
    // auto-repeat fires HZ edges after the first strobe, then every Q.
    int  e = 0;
    int  m, old_m, run_anchor, set_anchor, rep_start;
    bit  rep_active, sm, pm, si, pi_, rm, ri, held;
    bit  model_ok = 0;
    logic [1:0] x_mode;
    bit  x_tick, x_hr, x_min, x_clr, x_blink;

    task automatic strobe(input int md);
        if (md == 1) x_hr = 1'b1;
        else         x_min = 1'b1;
    endtask

    always @(posedge clk) begin
        e++;
        x_tick = 0; x_hr = 0; x_min = 0; x_clr = 0;
        if (rst) begin
            m = 0; run_anchor = e; rep_active = 0;
            sm = btn_mode; pm = btn_mode; si = btn_inc; pi_ = btn_inc;
            x_blink = 0;
            model_ok = 1;
        end else begin
            rm = sm && !pm;
            ri = si && !pi_;
            held = si;
            pm = sm; sm = btn_mode; pi_ = si; si = btn_inc;
            old_m = m;
            if (rm) begin
                m = (m + 1) % 3;
                rep_active = 0;
                if (old_m == 2) x_clr = 1;
                if (m == 0) run_anchor = e;
                if (old_m == 0) set_anchor = e;
            end else if (old_m != 0) begin
                if (ri) begin
                    strobe(old_m);
                    rep_active = 1;
                    rep_start = e;
                end else if (!held) begin
                    rep_active = 0;
                end else if (rep_active) begin
`ifdef CLOCK_AUTOREPEAT_EN
                    if (e - rep_start >= HZ && (e - rep_start - HZ) % Q == 0) strobe(old_m);
`endif
                end
            end else begin
                rep_active = 0;
            end
            x_tick  = (old_m == 0 && m == 0 && e != run_anchor && (e - run_anchor) % HZ == 0);
            x_blink = (m != 0) && (((e - set_anchor) / Q) % 2 == 0);
        end
        x_mode = 2'(m);
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("mode",     32'(mode),     32'(x_mode));
            chk("sec_tick", 32'(sec_tick), 32'(x_tick));
            chk("inc_hr",   32'(inc_hr),   32'(x_hr));
            chk("inc_min",  32'(inc_min),  32'(x_min));
            chk("clr_sec",  32'(clr_sec),  32'(x_clr));
            chk("blink",    32'(blink),    32'(x_blink));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; tick();
        btn_mode = 1'b0; tick();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; tick();
        btn_inc = 1'b0; tick();
    endtask

    int cnt;

    initial begin
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        tick(3);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_blink", 32'(blink), 0);
        rst = 1'b0;

        // First second tick after the HZ-th edge, one cycle wide
        tick(7);
        chk("tick_pre", 32'(sec_tick), 0);
        tick();
        chk("tick_first", 32'(sec_tick), 1);
        tick();
        chk("tick_width", 32'(sec_tick), 0);

        // Enter SET_HR: one-cycle latency, blink starts at 1, period 2+2
        btn_mode = 1'b1; tick();
        chk("mode_latency", 32'(mode), 0);
        btn_mode = 1'b0; tick();
        chk("mode_set_hr", 32'(mode), 1);
        chk("blink_start", 32'(blink), 1);
        tick();
        chk("blink_hold", 32'(blink), 1);
        tick();
        chk("blink_toggle", 32'(blink), 0);

        press_inc();
        chk("inc_hr_pulse", 32'(inc_hr), 1);
        tick();
        chk("inc_hr_width", 32'(inc_hr), 0);

        // Simultaneous rises: mode wins, no increment
        btn_mode = 1'b1; btn_inc = 1'b1; tick();
        btn_mode = 1'b0; btn_inc = 1'b0; tick();
        chk("simul_mode", 32'(mode), 2);
        chk("simul_no_inc", 32'(inc_hr | inc_min), 0);

        press_inc();
        chk("inc_min_1", 32'(inc_min), 1);
        press_inc();
        chk("inc_min_2", 32'(inc_min), 1);

        // Leave set mode: clr_sec with mode 0, next tick HZ edges later
        pulse_mode();
        chk("exit_mode", 32'(mode), 0);
        chk("exit_clr", 32'(clr_sec), 1);
        tick(7);
        chk("exit_tick_pre", 32'(sec_tick), 0);
        tick();
        chk("exit_tick", 32'(sec_tick), 1);

        // Held btn_inc in SET_MIN for 20 cycles
        pulse_mode(); pulse_mode();
        chk("ar_mode", 32'(mode), 2);
        cnt = 0;
        btn_inc = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); cnt += int'(inc_min); end
        btn_inc = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); cnt += int'(inc_min); end
`ifdef CLOCK_AUTOREPEAT_EN
        chk("ar_count", 32'(cnt), 7);
`else
        chk("ar_count", 32'(cnt), 1);
`endif

        // Reset in SET_HR with btn_inc held
        pulse_mode(); pulse_mode();
        chk("rst_test_mode", 32'(mode), 1);
        btn_inc = 1'b1; tick(2);
        chk("rst_test_inc", 32'(inc_hr), 1);
        rst = 1'b1; tick();
        chk("mid_rst_mode", 32'(mode), 0);
        chk("mid_rst_blink", 32'(blink), 0);
        chk("mid_rst_strobe", 32'(inc_hr | inc_min | clr_sec | sec_tick), 0);
        rst = 1'b0;
        pulse_mode();
        chk("after_rst_mode", 32'(mode), 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin tick(); cnt += int'(inc_hr); end
        chk("held_no_inc", 32'(cnt), 0);
        btn_inc = 1'b0; tick();
        press_inc();
        chk("repress_inc", 32'(inc_hr), 1);

        // Back to RUN, then btn_inc pulses must be ignored
        pulse_mode(); pulse_mode();
        chk("run_again", 32'(mode), 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            btn_inc = 1'b1; tick(); cnt += int'(inc_hr | inc_min);
            btn_inc = 1'b0; tick(); cnt += int'(inc_hr | inc_min);
        end
        chk("run_inc_ignored", 32'(cnt), 0);

        // Randomized buttons with occasional one-cycle resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)  btn_mode = ~btn_mode;
            if ($urandom_range(0, 11) == 0) btn_inc = ~btn_inc;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
